// File: rtl/piso_serializer.sv
// Parallel-in / serial-out word serializer with a one-word holding register
// and an optional idle gap between frames.
module piso_serializer #(
  parameter int WIDTH     = 24,
  parameter int MSB_FIRST = 0,
  parameter int GAP       = 0
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             serial,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);
  localparam int              CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);
  localparam logic [3:0]      GAP_LAST = 4'(GAP - 1);
  localparam int              OUT_BIT  = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic [WIDTH-1:0] shift_adv;
  logic             xfer, last_bit;

  assign load_ready   = !hold_full_q;
  assign xfer         = load_valid && !hold_full_q;
  assign serial_valid = (state_q == ST_SHIFT);
  assign last_bit     = serial_valid && (bit_cnt_q == LAST_BIT);
  assign serial       = serial_valid && shift_q[OUT_BIT];
  assign frame_start  = serial_valid && (bit_cnt_q == '0);
  assign frame_done   = last_bit;
  assign busy         = (state_q != ST_IDLE) || hold_full_q;
  assign shift_adv    = (MSB_FIRST != 0) ? {shift_q[WIDTH-2:0], 1'b0}
                                         : {1'b0, shift_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    // Default: an accepted word parks in the holding register; the idle
    // branch below overrides this when the shifter can take it directly.
    if (xfer) begin
      hold_d      = load_data;
      hold_full_d = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          bit_cnt_d   = '0;
          state_d     = ST_SHIFT;
        end else if (xfer) begin
          shift_d     = load_data;
          hold_d      = hold_q;
          hold_full_d = 1'b0;
          bit_cnt_d   = '0;
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_d   = shift_adv;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (last_bit) begin
          bit_cnt_d = '0;
          if (GAP != 0) begin
            gap_cnt_d = '0;
            state_d   = ST_GAP;
          end else if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            state_d     = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end
endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 24, word length in bits; legal range 2..64.
REQ-002 Parameter MSB_FIRST, default 0; 0 = bit 0 shifted first, 1 = bit WIDTH-1 shifted first.
REQ-003 Parameter GAP, default 0, number of idle cycles inserted between consecutive frames; legal range 0..15.
REQ-004 sys_clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 load_valid  input  1  load_data is offered this cycle.
REQ-007 load_data  input  WIDTH  parallel word to serialize.
REQ-008 load_ready  output  1  block can accept a word this cycle.
REQ-009 serial  output  1  current serial bit.
REQ-010 serial_valid  output  1  serial carries a frame bit this cycle.
REQ-011 frame_start  output  1  pulses with the first bit of each frame.
REQ-012 frame_done  output  1  pulses with the last bit of each frame.
REQ-013 busy  output  1  shifter active, in gap, or holding register full.

Function
REQ-014 The block has a shift register (WIDTH bits), a one-word holding register with flag hold_full, a bit counter of clog2(WIDTH+1) bits, and a gap counter of 4 bits.
REQ-015 The FSM has three states: IDLE, SHIFT and GAP.
REQ-016 A transfer occurs on a rising edge where load_valid and load_ready are both 1.
REQ-017 load_ready equals !hold_full and is independent of load_valid.
REQ-018 IDLE with hold_full=0 and a transfer at edge k: load_data goes directly to the shifter, the state moves to SHIFT, and the first bit is on serial with serial_valid=1 in the cycle after edge k.
REQ-019 A transfer in any other situation writes the holding register and sets hold_full=1.
REQ-020 In SHIFT, each edge advances one bit; exactly WIDTH consecutive cycles carry serial_valid=1, in the bit order set by MSB_FIRST.
REQ-021 frame_start=1 only in the first bit cycle of a frame, and frame_done=1 only in the last; both are 1 in no other cycle.
REQ-022 At the edge ending the last bit with GAP=0 and hold_full=1: the holding word moves to the shifter, hold_full clears, and the next frame's first bit follows with no idle cycle.
REQ-023 At the edge ending the last bit with GAP>0: the state moves to GAP for exactly GAP cycles with serial_valid=0, then goes to SHIFT if hold_full=1, otherwise to IDLE.
REQ-024 At the edge ending the last bit with GAP=0 and hold_full=0: the state moves to IDLE.
REQ-025 A transfer may complete at the same edge that empties the holding register into the shifter only if hold_full was 0 before that edge; a full holding register is never overwritten.
REQ-026 When serial_valid=0, serial shall be 0.
REQ-027 load_data is sampled only at a transfer edge; later changes on load_data have no effect.

Reset
REQ-028 While rst_n=0: state=IDLE, hold_full=0, counters=0, shifter=0; serial, serial_valid, frame_start, frame_done and busy are 0; load_ready=1.
REQ-029 Reset asserted mid-frame aborts the frame immediately and discards the shifter and holding contents; no partial frame resumes after rst_n rises.
REQ-030 The first transfer can occur on the first rising edge after rst_n deasserts.

Verification
REQ-031 WIDTH=24, MSB_FIRST=0, load 0xA5F00F -> serial sequence 1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1,1,0,1,0,0,1,0,1 over 24 valid cycles; frame_start in cycle 1, frame_done in cycle 24.
REQ-032 WIDTH=8, MSB_FIRST=1, load 0x81 -> serial sequence 1,0,0,0,0,0,0,1; serial_valid high for exactly 8 cycles.
REQ-033 WIDTH=8, GAP=0, load 0x55 then 0xAA back-to-back -> second transfer goes to the holding register; 16 contiguous valid cycles; load_ready low from the second transfer until the frame boundary.
REQ-034 WIDTH=8, GAP=3, two queued words -> exactly 3 cycles with serial_valid=0 between frame_done and the next frame_start.
REQ-035 Assert rst_n=0 at bit 5 of a frame with a word held -> all outputs are 0 and load_ready=1 immediately; after release no bits are emitted until a new transfer.
REQ-036 load_valid=1 held continuously with random data -> every accepted word is serialized exactly once, in order, and none is lost or duplicated.
